// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmit-core handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 core_valid;
    logic [7:0]           core_data;
    logic                 core_ready;
    logic                 core_done;
    logic [GID_W-1:0]     grant_id;
    logic                 busy;
    logic [CNT_W-1:0]     byte_cnt;

    // Environment side: requesters and transmit core
    modport master (
        output req_valid, req_data, req_last, core_ready, core_done,
        input  req_ready, core_valid, core_data, grant_id, busy, byte_cnt
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, core_ready, core_done,
        output req_ready, core_valid, core_data, grant_id, busy, byte_cnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding one UART tx core; `define UART_TX_ARB_LOCK_EN for packet lock
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic            tx_clk,
    input  logic            reset_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int GID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [GID_W-1:0] rr_q;
    logic [GID_W-1:0] grant_q;
    logic [GID_W-1:0] rr_next;
    logic [GID_W-1:0] arb_idx;
    logic [GID_W-1:0] scan_idx;
    logic [GID_W-1:0] cap_idx;
    logic             arb_found;
    logic             capture;
    logic             done_ok;
    logic             rr_adv;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] cnt_q;

`ifdef UART_TX_ARB_LOCK_EN
    logic             last_q;
    logic             lock_q;
    logic             lock_set;
    logic             lock_clr;
`else
    logic             unused_last;
    assign unused_last = ^bus.req_last;
`endif

    assign rr_next = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + GID_W'(1);

    // Pick the first valid requester at or after the rr pointer; a held lock narrows the choice to the owner
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_q;
        scan_idx  = rr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = GID_W'((int'(rr_q) + i) % NUM_REQ);
            if (!arb_found && bus.req_valid[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
`ifdef UART_TX_ARB_LOCK_EN
        if (lock_q) begin
            arb_found = bus.req_valid[grant_q];
            arb_idx   = grant_q;
        end
`endif
    end

    // State register
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept pulse and core handshake
    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        cap_idx        = grant_q;
        done_ok        = 1'b0;
        rr_adv         = 1'b0;
        bus.core_valid = 1'b0;
        bus.req_ready  = '0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_set       = 1'b0;
        lock_clr       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    capture = 1'b1;
                    cap_idx = arb_idx;
                    state_d = ST_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_clr = 1'b1;
`endif
                end
            end
            ST_ISSUE: begin
                if (bus.core_ready) begin
                    bus.core_valid = 1'b1;
                    state_d        = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.core_done) begin
                    done_ok = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
                    if (!last_q && bus.req_valid[grant_q]) begin
                        capture = 1'b1;
                        cap_idx = grant_q;
                        state_d = ST_ISSUE;
                    end else if (!last_q) begin
                        lock_set = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        rr_adv   = 1'b1;
                        lock_clr = 1'b1;
                        state_d  = ST_IDLE;
                    end
`else
                    rr_adv  = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Keep the accept pulse quiet while reset is held so no requester loses a byte to it
        if (!reset_n) begin
            capture = 1'b0;
        end
        if (capture) begin
            bus.req_ready[cap_idx] = 1'b1;
        end
    end

    // Capture the granted byte and grant index; data stays put through the core's load cycle
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 8'h00;
            grant_q <= '0;
        end else if (capture) begin
            data_q  <= bus.req_data[{cap_idx, 3'b000} +: 8];
            grant_q <= cap_idx;
        end
    end

    // Advance the round-robin pointer past the requester that just finished
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= '0;
        end else if (rr_adv) begin
            rr_q <= rr_next;
        end
    end

    // Count completed bytes, wrapping naturally
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (done_ok) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    // Track packet boundary and hold the grant until the requester's last byte
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            if (capture) begin
                last_q <= bus.req_last[cap_idx];
            end
            if (lock_set) begin
                lock_q <= 1'b1;
            end else if (lock_clr) begin
                lock_q <= 1'b0;
            end
        end
    end
`endif

    assign bus.core_data = data_q;
    assign bus.grant_id  = grant_q;
    assign bus.byte_cnt  = cnt_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int GW   = 2;
`ifdef UART_TX_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic tx_clk  = 1'b0;
    logic reset_n = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ), .CNT_W(CW)) bus();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .CNT_W(CW)) dut (
        .tx_clk  (tx_clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        int         req;
        logic [7:0] data;
        logic       last;
    } exp_t;

    int         errors    = 0;
    int         checks    = 0;
    int         rr_model  = 0;
    int         cnt_model = 0;
    int         stall_cnt = 0;
    exp_t       exp_q[$];
    logic [8:0] rq[NREQ][$];
    int         got_req[$];
    logic [7:0] got_data[$];

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                bus.req_valid[i]      = 1'b1;
                bus.req_data[8*i +: 8] = rq[i][0][7:0];
                bus.req_last[i]       = rq[i][0][8];
            end else begin
                bus.req_valid[i]      = 1'b0;
                bus.req_data[8*i +: 8] = 8'h00;
                bus.req_last[i]       = 1'b0;
            end
        end
    endtask

    // Expected byte order from the queued packets: round robin over requesters, whole packets under lock
    task automatic build_model();
        logic [8:0] mq[NREQ][$];
        exp_t e;
        int p;
        int g;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
        p = rr_model;
        while (1) begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && mq[(p + k) % NREQ].size() > 0) g = (p + k) % NREQ;
            if (g < 0) break;
            do begin
                e.req  = g;
                e.data = mq[g][0][7:0];
                e.last = mq[g][0][8];
                void'(mq[g].pop_front());
                exp_q.push_back(e);
            end while (LOCK && !e.last && mq[g].size() > 0);
            p = (g + 1) % NREQ;
        end
        rr_model = p;
    endtask

    task automatic do_reset();
        @(posedge tx_clk); #1;
        reset_n = 1'b0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        drive_reqs();
        bus.core_done  = 1'b0;
        bus.core_ready = 1'b1;
        rr_model  = 0;
        cnt_model = 0;
        @(posedge tx_clk); #1;
        reset_n = 1'b1;
    endtask

    // Play the queued traffic against a core model and check every cycle
    task automatic run_traffic(input int dmin, input int dmax, input int bpmin, input int bpmax, input int stop_after);
        int iss_ptr = 0;
        int cap_ptr = 0;
        int total;
        int cycles = 0;
        int cntdn = 0;
        int bp_left;
        bit pending = 0;
        bit inflight = 0;
        bit cd, cr, issued_now, done_now, expect_cap, lock_cont, nx_done, nx_ready;
        logic [7:0] stable_byte = 8'h00;
        logic [NREQ-1:0] exp_rdy;
        logic [GW-1:0] exp_gid;
        build_model();
        total = exp_q.size();
        got_req.delete();
        got_data.delete();
        bp_left = $urandom_range(bpmax, bpmin);
        @(posedge tx_clk); #1;
        drive_reqs();
        bus.core_done = 1'b0;
        if (bp_left > 0) begin bus.core_ready = 1'b0; bp_left--; end
        else bus.core_ready = 1'b1;
        while (1) begin
            @(negedge tx_clk);
            cycles++;
            cd = bus.core_done;
            cr = bus.core_ready;
            issued_now = 0;
            checks++;
            if (bus.byte_cnt !== CW'(cnt_model)) begin
                errors++; $display("FAIL byte_cnt: got %0d want %0d", bus.byte_cnt, CW'(cnt_model));
            end
            checks++;
            if (bus.busy !== (pending || inflight)) begin
                errors++; $display("FAIL busy: got %b want %b", bus.busy, (pending || inflight));
            end
            checks++;
            if (bus.core_valid !== (pending && cr)) begin
                errors++; $display("FAIL core_valid: got %b want %b", bus.core_valid, (pending && cr));
            end
            if (pending && !cr) stall_cnt++;
            done_now = cd && inflight;
            if (done_now) begin
                inflight = 0;
                cnt_model++;
                bp_left = $urandom_range(bpmax, bpmin);
            end
            if (bus.core_valid === 1'b1) begin
                issued_now = 1;
                if (iss_ptr < total) begin
                    exp_gid = GW'(exp_q[iss_ptr].req);
                    checks++;
                    if (bus.core_data !== exp_q[iss_ptr].data) begin
                        errors++; $display("FAIL issue_data: got %h want %h", bus.core_data, exp_q[iss_ptr].data);
                    end
                    checks++;
                    if (bus.grant_id !== exp_gid) begin
                        errors++; $display("FAIL issue_grant: got %0d want %0d", bus.grant_id, exp_gid);
                    end
                end else begin
                    checks++; errors++;
                    $display("FAIL extra_byte: got %h want none", bus.core_data);
                end
                got_req.push_back(int'(bus.grant_id));
                got_data.push_back(bus.core_data);
                stable_byte = bus.core_data;
                iss_ptr++;
                pending  = 0;
                inflight = 1;
                cntdn    = $urandom_range(dmax, dmin);
                if (stop_after > 0 && iss_ptr == stop_after) break;
            end else if (inflight) begin
                checks++;
                if (bus.core_data !== stable_byte) begin
                    errors++; $display("FAIL hold_data: got %h want %h", bus.core_data, stable_byte);
                end
            end else if (pending && iss_ptr < total) begin
                checks++;
                if (bus.core_data !== exp_q[iss_ptr].data) begin
                    errors++; $display("FAIL stall_data: got %h want %h", bus.core_data, exp_q[iss_ptr].data);
                end
            end
            lock_cont = LOCK && iss_ptr > 0 && iss_ptr <= total && !exp_q[iss_ptr-1].last;
            expect_cap = (cap_ptr < total) && !pending && !inflight && (!done_now || lock_cont);
            exp_rdy = '0;
            if (expect_cap) exp_rdy[exp_q[cap_ptr].req] = 1'b1;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++; $display("FAIL req_ready: got %b want %b", bus.req_ready, exp_rdy);
            end
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ready[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
            if (bus.req_ready !== '0) begin
                pending = 1;
                if (expect_cap) cap_ptr++;
            end
            nx_done = 0;
            if (!cd && inflight && !issued_now) begin
                cntdn--;
                if (cntdn <= 0) nx_done = 1;
            end
            if (inflight) nx_ready = 0;
            else if (bp_left > 0) begin nx_ready = 0; bp_left--; end
            else nx_ready = 1;
            if (iss_ptr >= total && !inflight && !pending && !cd) break;
            if (cycles > 3000) begin
                checks++; errors++;
                $display("FAIL traffic_timeout: got %0d bytes want %0d", iss_ptr, total);
                break;
            end
            @(posedge tx_clk); #1;
            drive_reqs();
            bus.core_done  = nx_done;
            bus.core_ready = nx_ready;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        drive_reqs();
        bus.core_done  = 1'b0;
        bus.core_ready = 1'b1;
        #12;
        checks++; if (bus.core_valid !== 1'b0) begin errors++; $display("FAIL rst_core_valid: got %b want 0", bus.core_valid); end
        checks++; if (bus.core_data !== 8'h00) begin errors++; $display("FAIL rst_core_data: got %h want 00", bus.core_data); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d want 0", bus.grant_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.byte_cnt !== 4'd0) begin errors++; $display("FAIL rst_byte_cnt: got %0d want 0", bus.byte_cnt); end
        @(posedge tx_clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        rq[0].push_back({1'b1, 8'hA5});
        run_traffic(12, 12, 0, 0, 0);
        checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_data.size()); end
        else begin
            checks++; if (got_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", got_data[0]); end
        end
        checks++; if (bus.byte_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", bus.byte_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_fairness();
        int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, 8'($urandom)});
        run_traffic(1, 4, 0, 0, 0);
        checks++;
        if (got_req.size() !== 8) begin errors++; $display("FAIL fair_count: got %0d want 8", got_req.size()); end
        else for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_req[k] !== order[k]) begin errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, got_req[k], order[k]); end
        end
    endtask

    task automatic test_backpressure();
        stall_cnt = 0;
        rq[2].push_back({1'b1, 8'h3C});
        rq[2].push_back({1'b1, 8'hC3});
        run_traffic(2, 5, 6, 6, 0);
        checks++;
        if (stall_cnt !== 10) begin errors++; $display("FAIL bp_stalls: got %0d want 10", stall_cnt); end
    endtask

    task automatic test_lock();
        logic [7:0] want[4];
        if (LOCK) want = '{8'h11, 8'h22, 8'h33, 8'h44};
        else      want = '{8'h11, 8'h44, 8'h22, 8'h33};
        do_reset();
        rq[0].push_back({1'b0, 8'h11});
        rq[0].push_back({1'b0, 8'h22});
        rq[0].push_back({1'b1, 8'h33});
        rq[1].push_back({1'b1, 8'h44});
        run_traffic(1, 3, 0, 1, 0);
        checks++;
        if (got_data.size() !== 4) begin errors++; $display("FAIL lock_count: got %0d want 4", got_data.size()); end
        else for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_data[k] !== want[k]) begin errors++; $display("FAIL lock_order[%0d]: got %h want %h", k, got_data[k], want[k]); end
        end
    endtask

    task automatic test_spurious_done();
        @(posedge tx_clk); #1;
        bus.core_done = 1'b1;
        repeat (3) @(posedge tx_clk);
        #1;
        bus.core_done = 1'b0;
        @(negedge tx_clk);
        checks++; if (bus.byte_cnt !== CW'(cnt_model)) begin errors++; $display("FAIL spurious_cnt: got %0d want %0d", bus.byte_cnt, CW'(cnt_model)); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL spurious_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, 8'($urandom)});
        run_traffic(6, 6, 0, 0, 3);
        @(posedge tx_clk); #3;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.core_valid !== 1'b0) begin errors++; $display("FAIL mid_core_valid: got %b want 0", bus.core_valid); end
        checks++; if (bus.core_data !== 8'h00) begin errors++; $display("FAIL mid_core_data: got %h want 00", bus.core_data); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_req_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant_id: got %0d want 0", bus.grant_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.byte_cnt !== 4'd0) begin errors++; $display("FAIL mid_byte_cnt: got %0d want 0", bus.byte_cnt); end
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        drive_reqs();
        bus.core_done  = 1'b0;
        bus.core_ready = 1'b1;
        rr_model  = 0;
        cnt_model = 0;
        @(posedge tx_clk); #1;
        reset_n = 1'b1;
        rq[1].push_back({1'b1, 8'h5A});
        rq[3].push_back({1'b1, 8'hE7});
        run_traffic(1, 3, 0, 0, 0);
        checks++;
        if (got_req.size() < 1 || got_req[0] !== 1) begin
            errors++; $display("FAIL mid_restart_grant: got %0d want 1", (got_req.size() > 0) ? got_req[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int np = $urandom_range(2, 0);
                for (int p = 0; p < np; p++) begin
                    int len = $urandom_range(3, 1);
                    for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            run_traffic(1, 6, 0, 3, 0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 17; k++) rq[$urandom_range(NREQ - 1, 0)].push_back({1'b1, 8'($urandom)});
        run_traffic(1, 3, 0, 1, 0);
        checks++;
        if (bus.byte_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d want 1", bus.byte_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_lock();
        test_spurious_done();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
